mul_seq: RTL and testbench

- Iterative multiply sequencer for the multicycle ARM core. Executes MUL, UMULL and SMULL with a radix-2 shift-add loop.
- The main FSM holds in its execute state from start until the done pulse, then writes result_lo/result_hi back through the register-file path.
- Sits beside the ALU and shares the same operand sources (SrcA/SrcB); it does not replace the ALU.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_seq_dp.sv | 69 ++++++
 rtl/mul_seq.sv | 112 +++++++++++
 tb/tb_mul_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared encodings for the iterative multiply sequencer: operation codes,
// FSM state names and the default operand width.
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        MUL_OP_MUL   = 2'b00,
        MUL_OP_UMULL = 2'b01,
        MUL_OP_SMULL = 2'b10,
        MUL_OP_RSVD  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mul_state_e;

endpackage

// File: rtl/mul_seq_dp.sv
// Datapath for the radix-2 shift-add multiplier: operand magnitudes, the
// 2*WIDTH accumulator, the multiplier shift register and the final sign fix.
module mul_seq_dp #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 fix,
    input  logic                 smull,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   final_val,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi
);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   mplier_d;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] res_q;
    logic               neg_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;

    always_comb begin
        a_mag = (smull && a[WIDTH-1]) ? (~a + ONE_W) : a;
        b_mag = (smull && b[WIDTH-1]) ? (~b + ONE_W) : b;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        // Shift {carry, accumulator, multiplier} right by one as a single word.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
        final_val = neg_q ? (~acc_q + ONE_2W) : acc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
        end else begin
            if (load) begin
                mcand_q  <= a_mag;
                mplier_q <= b_mag;
                acc_q    <= '0;
                neg_q    <= smull & (a[WIDTH-1] ^ b[WIDTH-1]);
            end else if (step) begin
                acc_q    <= acc_d;
                mplier_q <= mplier_d;
            end
            if (fix) begin
                res_q <= final_val;
            end
        end
    end

    assign result_lo = res_q[WIDTH-1:0];
    assign result_hi = res_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mul_seq.sv
// Multiply sequencer: IDLE/RUN/FIX/DONE control, iteration counter and
// N/Z flag registers around the shift-add datapath.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic               busy_q;
    logic               done_q;
    logic               flag_n_q;
    logic               flag_z_q;
    logic               flag_n_d;
    logic               flag_z_d;
    logic               load;
    logic               step;
    logic               fix;
    logic               is_mul;
    logic [2*WIDTH-1:0] final_val;

    assign load   = (state_q == S_IDLE) && start;
    assign step   = (state_q == S_RUN);
    assign fix    = (state_q == S_FIX);
    assign is_mul = (op_q == MUL_OP_MUL);

    // MUL reports flags on the low word only; the long forms use all 2*WIDTH bits.
    always_comb begin
        flag_n_d = is_mul ? final_val[WIDTH-1] : final_val[2*WIDTH-1];
        flag_z_d = is_mul ? ~|final_val[WIDTH-1:0] : ~|final_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= MUL_OP_MUL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    flag_n_q <= flag_n_d;
                    flag_z_q <= flag_z_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .smull     (op == MUL_OP_SMULL),
        .a         (a),
        .b         (b),
        .final_val (final_val),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed and random operations compared
// against an arithmetic reference model, plus handshake and reset-abort cases.
module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        flag_n;
    logic        flag_z;

    int n_checks = 0;
    int n_errors = 0;
    logic [65:0] exp_q[$];

    mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {flag_n, flag_z, product} from plain integer arithmetic.
    function automatic logic [65:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        logic        n;
        logic        z;
        if (o == 2'b10) begin
            sx = longint'(signed'(x));
            sy = longint'(signed'(y));
            p  = 64'(sx * sy);
        end else begin
            p = {32'b0, x} * {32'b0, y};
        end
        n = (o == 2'b00) ? p[31] : p[63];
        z = (o == 2'b00) ? (p[31:0] == 32'b0) : (p == 64'b0);
        return {n, z, p};
    endfunction

    task automatic check_result(input string tag);
        logic [65:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_lo"}, result_lo, e[31:0]);
            check({tag, "_hi"}, result_hi, e[63:32]);
            check({tag, "_n"}, flag_n, e[65]);
            check({tag, "_z"}, flag_z, e[64]);
        end
    endtask

    // One operation: accept, scramble inputs while busy, check latency and results.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int   cyc;
        logic busy_ok;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 40) begin
            if (!busy) busy_ok = 1'b0;
            a = $urandom;
            b = $urandom;
            op = 2'($urandom_range(0, 3));
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_busy_run"}, busy_ok, 1);
        check({tag, "_latency"}, cyc, 34);
        check({tag, "_busy_done"}, busy, 1);
        check_result(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int          seen;
        int          cyc;
        logic [31:0] x;
        logic [31:0] y;

        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {result_hi, result_lo}, 64'd0);
        check("rst_flags", {flag_n, flag_z}, 2'b00);

        do_op("umull_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("umull_ff_const", {result_hi, result_lo, flag_n, flag_z}, {32'hFFFF_FFFE, 32'h0000_0001, 2'b10});
        do_op("mul_7x6", 2'b00, 32'd7, 32'd6);
        check("mul_7x6_const", {result_hi, result_lo}, 64'h0000_0000_0000_002A);
        do_op("smull_m2x3", 2'b10, 32'hFFFF_FFFE, 32'd3);
        do_op("smull_min", 2'b10, 32'h8000_0000, 32'h8000_0000);
        do_op("smull_zero", 2'b10, 32'd0, 32'hFFFF_FFFF);
        do_op("rsvd_op", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001);
        do_op("mul_hi", 2'b00, 32'hFFFF_FFFF, 32'h0000_0010);
        do_op("smull_pos_neg", 2'b10, 32'h7FFF_FFFF, 32'h8000_0000);

        // start held high: one completes, the next is taken only from IDLE
        x = 32'h1234_5678; y = 32'h9ABC_DEF0;
        @(negedge clk);
        op = 2'b01; a = x; b = y; start = 1'b1;
        exp_q.push_back(model(2'b01, x, y));
        exp_q.push_back(model(2'b01, x, y));
        seen = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen++;
                check(i == 34 ? "hold_first_lat" : "hold_first_lat_bad", i, 34);
                check_result("hold_first");
            end
        end
        start = 1'b0;
        check("hold_one_done", seen, 1);
        check("hold_second_busy", busy, 1);
        cyc = 40;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("hold_second_lat", cyc, 69);
        check_result("hold_second");

        // reset during RUN aborts without a done pulse
        @(negedge clk);
        op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_1001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_res", {result_hi, result_lo}, 64'd0);
        check("abort_flags", {flag_n, flag_z}, 2'b00);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort_quiet", seen, 0);
        do_op("after_abort", 2'b10, 32'hFFFF_FFF9, 32'h0000_0005);

        for (int i = 0; i < 20; i++) begin
            do_op("rand", 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
